// File: rtl/leiwand_rv32_wb_arbiter.sv
// Two-master Wishbone arbiter: CPU core (m0) and loader/DMA (m1) share one bus, round-robin on ties.
// Optional no-ack watchdog compiled in with `define LEIWAND_RV32_WB_ARB_TIMEOUT_EN.
module leiwand_rv32_wb_arbiter #(
  parameter int unsigned MEM_WIDTH      = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 m0_cyc,
  input  logic                 m0_stb,
  input  logic                 m0_we,
  input  logic [MEM_WIDTH-1:0] m0_addr,
  input  logic [MEM_WIDTH-1:0] m0_data_out,
  output logic [MEM_WIDTH-1:0] m0_data_in,
  output logic                 m0_ack,
  output logic                 m0_stall,
  input  logic                 m1_cyc,
  input  logic                 m1_stb,
  input  logic                 m1_we,
  input  logic [MEM_WIDTH-1:0] m1_addr,
  input  logic [MEM_WIDTH-1:0] m1_data_out,
  output logic [MEM_WIDTH-1:0] m1_data_in,
  output logic                 m1_ack,
  output logic                 m1_stall,
  output logic                 s_cyc,
  output logic                 s_stb,
  output logic                 s_we,
  output logic [MEM_WIDTH-1:0] s_addr,
  output logic [MEM_WIDTH-1:0] s_data_out,
  input  logic [MEM_WIDTH-1:0] s_data_in,
  input  logic                 s_ack,
  input  logic                 s_stall,
  output logic [1:0]           grant,
  output logic                 timeout_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  state_t state;
  state_t state_next;
  logic   last_m1;
  logic   last_m1_next;
  logic   wd_hit;

  // State and last-served register; reset leaves m1 as last served so m0 wins the first tie.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      last_m1 <= 1'b1;
    end else begin
      state   <= state_next;
      last_m1 <= last_m1_next;
    end
  end

  // Next-state: ownership only moves once the owner drops cyc; handover skips IDLE.
  always_comb begin
    state_next   = state;
    last_m1_next = last_m1;
    case (state)
      IDLE: begin
        if (m0_cyc && m1_cyc) state_next = last_m1 ? OWN0 : OWN1;
        else if (m0_cyc)      state_next = OWN0;
        else if (m1_cyc)      state_next = OWN1;
      end
      OWN0: if (!m0_cyc) state_next = m1_cyc ? OWN1 : IDLE;
      OWN1: if (!m1_cyc) state_next = m0_cyc ? OWN0 : IDLE;
      default: state_next = IDLE;
    endcase
    if (state_next != state) begin
      if (state_next == OWN0) last_m1_next = 1'b0;
      if (state_next == OWN1) last_m1_next = 1'b1;
    end
  end

`ifdef LEIWAND_RV32_WB_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  logic [CNT_W-1:0] wd_cnt;
  logic             owner_cyc;

  assign owner_cyc = ((state == OWN0) && m0_cyc) || ((state == OWN1) && m1_cyc);
  assign wd_hit    = (state != IDLE) && (wd_cnt == CNT_W'(TIMEOUT_CYCLES));

  // Counts owned cycles without an ack; any progress, release or handover restarts it.
  always_ff @(posedge clk) begin
    if (reset) begin
      wd_cnt <= '0;
    end else if ((state_next != state) || (state == IDLE) || s_ack || !owner_cyc || wd_hit) begin
      wd_cnt <= '0;
    end else begin
      wd_cnt <= wd_cnt + CNT_W'(1);
    end
  end
`else
  assign wd_hit = 1'b0;
`endif

  assign timeout_err = wd_hit;
  assign grant       = {state == OWN1, state == OWN0};

  // Bus steering; a watchdog hit fakes an ack with zero data toward the owner.
  always_comb begin
    s_cyc      = 1'b0;
    s_stb      = 1'b0;
    s_we       = 1'b0;
    s_addr     = '0;
    s_data_out = '0;
    m0_data_in = '0;
    m0_ack     = 1'b0;
    m0_stall   = 1'b1;
    m1_data_in = '0;
    m1_ack     = 1'b0;
    m1_stall   = 1'b1;
    case (state)
      OWN0: begin
        s_cyc      = m0_cyc;
        s_stb      = m0_stb;
        s_we       = m0_we;
        s_addr     = m0_addr;
        s_data_out = m0_data_out;
        m0_data_in = wd_hit ? '0 : s_data_in;
        m0_ack     = s_ack | wd_hit;
        m0_stall   = s_stall;
      end
      OWN1: begin
        s_cyc      = m1_cyc;
        s_stb      = m1_stb;
        s_we       = m1_we;
        s_addr     = m1_addr;
        s_data_out = m1_data_out;
        m1_data_in = wd_hit ? '0 : s_data_in;
        m1_ack     = s_ack | wd_hit;
        m1_stall   = s_stall;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/leiwand_rv32_wb_arbiter.md
LEIWAND_RV32_WB_ARBITER -- requirements
Module: leiwand_rv32_wb_arbiter

Interface
REQ-001 SHALL have parameter MEM_WIDTH, default 32, the address and data width.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 255, the no-ack cycle limit used by the watchdog (Configuration).
REQ-003 clk  input  1  sole clock; all state changes on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 m0_cyc, m0_stb, m0_we  input  1 each  master 0 (CPU core) Wishbone cycle, strobe and write-enable.
REQ-006 m0_addr, m0_data_out  input  MEM_WIDTH each  master 0 address and write data.
REQ-007 m0_data_in  output  MEM_WIDTH  master 0 read data.
REQ-008 m0_ack, m0_stall  output  1 each  master 0 acknowledge and stall.
REQ-009 m1_* (cyc, stb, we, addr, data_out, data_in, ack, stall)  same directions and widths as m0_*  master 1 (loader/DMA).
REQ-010 s_cyc, s_stb, s_we  output  1 each  shared-bus cycle, strobe and write-enable toward the address decoder.
REQ-011 s_addr, s_data_out  output  MEM_WIDTH each  shared-bus address and write data.
REQ-012 s_data_in  input  MEM_WIDTH  shared-bus read data (OR of slave data).
REQ-013 s_ack, s_stall  input  1 each  shared-bus acknowledge and stall.
REQ-014 grant  output  2  one-hot owner: 2'b01 = m0, 2'b10 = m1, 2'b00 = idle.
REQ-015 timeout_err  output  1  one-cycle pulse when the watchdog terminates a cycle.

Function
REQ-016 SHALL implement registered states IDLE, OWN0, OWN1; grant SHALL be the direct decode of the state.
REQ-017 IDLE: only m0_cyc -> OWN0; only m1_cyc -> OWN1; both -> the master not served last (round-robin); neither -> stay IDLE.
REQ-018 Grant latency SHALL be exactly one clock from cyc assertion seen in IDLE to the owner's s_cyc.
REQ-019 OWNn: s_cyc, s_stb, s_we, s_addr and s_data_out SHALL combinationally equal master n's signals; mn_data_in = s_data_in, mn_ack = s_ack, mn_stall = s_stall.
REQ-020 Non-owner SHALL see stall=1, ack=0, data_in=0 at all times.
REQ-021 IDLE: s_cyc=0, s_stb=0, s_we=0, s_addr=0, s_data_out=0; both masters stall=1, ack=0, data_in=0.
REQ-022 OWNn with mn_cyc=0: other master requesting -> OWN(other) next cycle (no idle gap); otherwise -> IDLE.
REQ-023 Ownership SHALL NOT change while the owner holds cyc, regardless of the other's requests.
REQ-024 Last-served flag SHALL update on every entry into OWN0/OWN1.
REQ-025 An s_ack arriving in IDLE SHALL be discarded (not forwarded to any master).

Reset
REQ-026 reset=1 at a rising edge SHALL force IDLE, last-served = m1 (m0 wins first tie), watchdog count 0 and timeout_err 0, overriding all other inputs including a cycle in progress.
REQ-027 After reset all outputs SHALL hold the IDLE values of REQ-021 with grant=2'b00.

Configuration
REQ-028 Macro LEIWAND_RV32_WB_ARB_TIMEOUT_EN SHALL compile in the watchdog; without it timeout_err SHALL be tied 0 and no counter SHALL exist.
REQ-029 With the macro, a counter SHALL clear on state entry, on s_ack and when the owner's cyc=0, and otherwise increment each OWNn cycle.
REQ-030 With the macro, when the counter reaches TIMEOUT_CYCLES the owner SHALL receive ack=1 with data_in=0 for that one cycle, timeout_err SHALL pulse that cycle, and the counter SHALL clear.

Verification
REQ-031 m0 single read at 0x20400000, slave acks 2 cycles after stb -> grant=01 one cycle after m0_cyc, m0_data_in = slave word with m0_ack, then IDLE.
REQ-032 m0_cyc and m1_cyc rise same cycle after reset -> m0 owns first; when m0 drops cyc, OWN1 next cycle with no IDLE gap.
REQ-033 m1 holds cyc for 10 transfers while m0 requests -> grant stays 10 until m1_cyc=0; m0_stall=1 and m0_ack=0 throughout.
REQ-034 reset asserted mid-transfer in OWN1 -> next edge grant=00, s_cyc=0, m1_stall=1; the next simultaneous request goes to m0.
REQ-035 With LEIWAND_RV32_WB_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8, m0 strobes unmapped 0x00000000, slave never acks -> after 8 cycles m0_ack=1, m0_data_in=0, timeout_err=1 for one cycle.
REQ-036 Without the macro, same stimulus -> no ack ever, timeout_err stays 0, grant stays 01.
